// File: rtl/apple1_char_sender.sv
// apple1_char_sender: host-side character transmitter for the Apple-1 style
// video terminal. Characters are queued in a small FIFO and handed to the
// terminal one at a time with the DA/RDA handshake. The character bus is
// driven through a tristate gated by out_en_n.
module apple1_char_sender #(
  parameter int DATA_W  = 7,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              busy,
  input  logic              out_en_n,
  output logic [DATA_W-1:0] dout,
  output logic              da,
  input  logic              rda,
  input  logic              err_clr,
  output logic              timeout_err
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_READY} state_t;

  state_t             state, state_nx;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]  rd_ptr, wr_ptr;
  logic [ADDR_W:0]    count, count_nx;
  logic [DATA_W-1:0]  hold;
  logic [CNT_W-1:0]   tcnt;
  logic               push, pop, tmo_hit;

  // full is sampled as registered, so a push while full is rejected even
  // when a pop happens on the same edge.
  assign push = wr_en & ~full;
  assign pop  = (state == IDLE) & ~empty & rda;

  assign da    = (state == WAIT_ACK);
  assign busy  = ~empty | (state != IDLE);
  assign dout  = out_en_n ? {DATA_W{1'bz}} : hold;

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + 1'b1;
    else if (pop && !push) count_nx = count - 1'b1;
  end

  // FIFO pointers, occupancy and registered full/empty decodes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      full  <= (count_nx == CNT_FULL);
      empty <= (count_nx == '0);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Handshake next-state logic.
  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    case (state)
      IDLE:       if (pop) state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (!rda) begin
          state_nx = WAIT_READY;
        end else if ((TIMEOUT != 0) && (tcnt == CNT_LAST)) begin
          // Give up on this character; it is not retried.
          state_nx = WAIT_READY;
          tmo_hit  = 1'b1;
        end
      end
      WAIT_READY: if (rda) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // State, hold register, timeout counter and sticky error flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      hold        <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) begin
        hold <= mem[rd_ptr];
        tcnt <= '0;
      end else if (state == WAIT_ACK) begin
        tcnt <= tcnt + 1'b1;
      end
      // A new timeout outranks a clear in the same cycle.
      if (tmo_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: doc/apple1_char_sender.md
Name: apple1_char_sender

Overview:
- Transmit end of the terminal character interface: the host-side counterpart to the terminal's character input register.
- Buffers characters from the host/CPU glue in a small FIFO, then presents them one at a time to the video terminal using the DA/RDA handshake.
- Drives the shared character bus through a tristate output gated by an active-low enable, so it can share the bus with other drivers.

Parameters:
- DATA_W, 7, character width in bits (ASCII, bit 7 not carried).
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 2, log2(DEPTH).
- TIMEOUT, 1024, maximum cycles to wait in WAIT_ACK; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- wr_en  in  1  host write strobe, one character per cycle.
- wr_data  in  DATA_W  character to enqueue.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  FIFO non-empty, or FSM not in IDLE.
- out_en_n  in  1  bus output enable, active-low.
- dout  out  DATA_W  character bus; Z whenever out_en_n=1.
- da  out  1  data-available strobe to the terminal, active-high.
- rda  in  1  terminal ready-for-data, active-high; already synchronous to clk.
- err_clr  in  1  synchronous clear of timeout_err.
- timeout_err  out  1  sticky flag: a handshake timed out.

Behaviour:
- Reset (clr=1), asynchronous, takes effect immediately:
  - FIFO count, read pointer and write pointer = 0.
  - Hold register = 0; state = IDLE.
  - da=0, full=0, empty=1, busy=0, timeout_err=0.
  - dout is Z if out_en_n=1, else 0.
- Reset asserted mid-transfer: da drops immediately and all queued characters are discarded.
- dout is combinational from the hold register and out_en_n. It is independent of state; the hold register keeps the last sent character.
- FIFO write:
  - Accepted on a clock edge when wr_en=1 and full=0.
  - A write while full is silently dropped; FIFO contents are unchanged.
  - full and empty are registered count decodes.
- FIFO read (pop) is performed only by the FSM, in IDLE.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Push while full in the same cycle as a pop: the push is still rejected, because full was 1 at the edge.
- Pointers wrap modulo DEPTH.
- States: IDLE, WAIT_ACK, WAIT_READY.
- IDLE:
  - Condition: empty=0 and rda=1 at the edge.
  - Action: hold <= FIFO head, pop, da <= 1, timeout counter <= 0, go to WAIT_ACK.
  - Otherwise remain in IDLE with da=0.
- WAIT_ACK:
  - da stays 1 and the timeout counter increments.
  - If rda=0: da <= 0, go to WAIT_READY.
  - Else if TIMEOUT!=0 and counter = TIMEOUT-1: da <= 0, timeout_err <= 1, go to WAIT_READY. The character counts as sent and is not retried.
- WAIT_READY: da=0; when rda=1, go to IDLE.
- Latency:
  - A write into an empty FIFO with an idle FSM and rda held 1 gives da=1 two edges after the write edge (one edge to enqueue, one to pop).
  - With an instant-acknowledging terminal, the minimum spacing between da rising edges is 3 cycles.
- rda already low in IDLE: no pop; the FSM waits.
- timeout_err:
  - Cleared by err_clr=1 at an edge.
  - If set and clear occur in the same cycle, set wins.
- busy = (empty=0) OR (state != IDLE).

Test Plan:
- Reset/tristate:
  - Assert clr mid-WAIT_ACK -> da=0 immediately; empty=1, busy=0, state=IDLE.
  - With out_en_n=1 -> dout=Z.
  - With out_en_n=0 -> dout=0x00.
- Single character:
  - rda=1; write 0x41; terminal drops rda 2 cycles after da rises, restores it 3 cycles later.
  - Required: da rises 2 edges after the write, dout=0x41, da falls the edge after rda=0, FSM returns to IDLE on rda=1.
- Fill/overflow:
  - Hold rda=0; write 0x31,0x32,0x33,0x34,0x35 on consecutive cycles.
  - Required: full=1 after the 4th write; 0x35 dropped.
  - Release the handshake: exactly 0x31..0x34 sent in order, then empty=1.
- Simultaneous push/pop:
  - FIFO has 1 entry; write 0x50 on the same edge the FSM pops.
  - Required: count stays 1; 0x50 sent next.
- Pointer wrap: stream 10 characters 0x40..0x49 with instant ack -> all received in order, no loss, spacing of 3 cycles.
- Timeout:
  - TIMEOUT=8, rda stuck 1 after da rises -> da falls after 8 cycles in WAIT_ACK and timeout_err=1.
  - err_clr -> timeout_err=0.
